// File: rtl/concat_seq_pkg.sv
// Shared widths, state encodings and tag values for the concat_seq sequencer and its packer.
package concat_seq_pkg;

  localparam int FIELD_W = 6;
  localparam int X1_W    = 11;
  localparam int X2_W    = 6;
  localparam int TAG_W   = 2;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [1:0]         state_t;

  localparam state_t S_F1  = 2'd0;
  localparam state_t S_F2  = 2'd1;
  localparam state_t S_F3  = 2'd2;
  localparam state_t S_OUT = 2'd3;

  localparam tag_t TAG_F1 = 2'd0;
  localparam tag_t TAG_F2 = 2'd1;
  localparam tag_t TAG_F3 = 2'd2;

endpackage

// File: rtl/concat_seq_pack.sv
// Purely combinational bit-swizzle packer: three 6-bit fields into the x1/x2 words.
module concat_seq_pack
  import concat_seq_pkg::*;
(
  input  field_t          f1_i,
  input  field_t          f2_i,
  input  field_t          f3_i,
  output logic [X1_W-1:0] x1_o,
  output logic [X2_W-1:0] x2_o
);

  logic unused_bits;

  assign x1_o = {f1_i[3:2], f2_i[4:0], f3_i[1:0], f1_i[1:0]};
  assign x2_o = {f1_i[1], f2_i[5:2], f1_i[0]};

  // These field bits carry no information in the packed format.
  assign unused_bits = ^{f1_i[5:4], f3_i[5:2]};

endmodule

// File: rtl/concat_seq.sv
// Collects tagged F1/F2/F3 beats, packs them, and holds the packed words on a valid/ready output.
module concat_seq
  import concat_seq_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [FIELD_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X1_W-1:0]  x1,
  output logic [X2_W-1:0]  x2,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  field_t            f1_q, f1_d, f2_q, f2_d;
  logic [X1_W-1:0]   x1_q, x1_d, pack_x1;
  logic [X2_W-1:0]   x2_q, x2_d, pack_x2;
  logic              out_valid_q, out_valid_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q;
  logic [CNT_W-1:0]  frame_cnt_q, err_cnt_q;
  logic              accept, abort, frame_done;

  // F3 goes straight from the bus into the packer so x1/x2 load on the accepting edge.
  concat_seq_pack u_pack (
    .f1_i (f1_q),
    .f2_i (f2_q),
    .f3_i (in_data),
    .x1_o (pack_x1),
    .x2_o (pack_x2)
  );

  assign in_ready = (state_q != S_OUT);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    f1_d        = f1_q;
    f2_d        = f2_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    out_valid_d = out_valid_q;
    idle_d      = idle_q;
    abort       = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      S_F1: begin
        if (accept) begin
          if (in_tag == TAG_F1) begin
            f1_d    = in_data;
            idle_d  = '0;
            state_d = S_F2;
          end else begin
            abort = 1'b1;
          end
        end
      end
      S_F2, S_F3: begin
        // An accept in the would-be timeout cycle wins over the timeout.
        if (accept) begin
          idle_d = '0;
          if (state_q == S_F2 && in_tag == TAG_F2) begin
            f2_d    = in_data;
            state_d = S_F3;
          end else if (state_q == S_F3 && in_tag == TAG_F3) begin
            x1_d        = pack_x1;
            x2_d        = pack_x2;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            abort   = 1'b1;
            state_d = S_F1;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          idle_d  = '0;
          state_d = S_F1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_done  = 1'b1;
          state_d     = S_F1;
        end
      end
      default: state_d = S_F1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_F1;
      f1_q        <= '0;
      f2_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      out_valid_q <= 1'b0;
      idle_q      <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      out_valid_q <= out_valid_d;
      idle_q      <= idle_d;
      err_q       <= abort;
      if (frame_done)
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      // The abort count sticks at all-ones rather than wrapping.
      if (abort && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign busy      = (state_q == S_F2) || (state_q == S_F3);
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_concat_seq.sv
// Directed bench for concat_seq: stimulus pushes expected packed words, a negedge monitor checks them.
module tb_concat_seq;
  import concat_seq_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag = '0;
  logic [FIELD_W-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [X1_W-1:0]  x1;
  logic [X2_W-1:0]  x2;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [X1_W+X2_W-1:0] sb[$];

  // Hand-packed reference frames: {f1, f2, f3, x1, x2}.
  typedef struct {
    logic [5:0]  f1, f2, f3;
    logic [10:0] ex1;
    logic [5:0]  ex2;
  } frame_t;
  frame_t frames[3];

  concat_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x1        (x1),
    .x2        (x2),
    .busy      (busy),
    .err       (err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds a beat on the bus until the DUT takes it; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [1:0] tag, input logic [5:0] data);
    logic taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_tag   = tag;
    in_data  = data;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!taken) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL beat_accept: got no accept, expected accept within 50 cycles");
    end
  endtask

  task automatic sendFrame(input int idx);
    sb.push_back({frames[idx].ex1, frames[idx].ex2});
    applyStimulus(TAG_F1, frames[idx].f1);
    applyStimulus(TAG_F2, frames[idx].f2);
    applyStimulus(TAG_F3, frames[idx].f3);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Compares every valid cycle against the queue head so held words must stay stable.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_word: got x1=0x%0h x2=0x%0h, expected no output", x1, x2);
      end else begin
        checkOutput("packed_word", {15'd0, x1, x2}, {15'd0, sb[0]});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frames[0] = '{6'h2D, 6'h15, 6'h3E, 11'h759, 6'h0B};
    frames[1] = '{6'h3F, 6'h00, 6'h03, 11'h60F, 6'h21};
    frames[2] = '{6'h00, 6'h3F, 6'h00, 11'h1F0, 6'h1E};

    doReset();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_x1x2", {x1, x2}, 0);

    // Back-to-back frame with the consumer always ready.
    out_ready = 1'b1;
    sb.push_back({frames[0].ex1, frames[0].ex2});
    applyStimulus(TAG_F1, frames[0].f1);
    checkOutput("t1_busy_f2", busy, 1);
    applyStimulus(TAG_F2, frames[0].f2);
    applyStimulus(TAG_F3, frames[0].f3);
    checkOutput("t1_out_valid", out_valid, 1);
    checkOutput("t1_in_ready_out", in_ready, 0);
    @(posedge clk); #1;
    checkOutput("t1_out_valid_drop", out_valid, 0);
    checkOutput("t1_frame_cnt", frame_cnt, 1);

    // Consumer stalls for 5 cycles.
    doReset();
    out_ready = 1'b0;
    sendFrame(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("t2_hold_valid", out_valid, 1);
      checkOutput("t2_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("t2_out_valid_drop", out_valid, 0);
    checkOutput("t2_frame_cnt", frame_cnt, 1);

    // Tag errors in every position, then a clean frame.
    doReset();
    applyStimulus(TAG_F1, 6'h01);
    applyStimulus(TAG_F3, 6'h02);
    checkOutput("t3_err_skip", err, 1);
    checkOutput("t3_busy_after_err", busy, 0);
    checkOutput("t3_err_cnt1", err_cnt, 1);
    @(posedge clk); #1;
    checkOutput("t3_err_one_cycle", err, 0);
    applyStimulus(TAG_F1, 6'h01);
    applyStimulus(TAG_F1, 6'h02);
    checkOutput("t3_err_f1_in_f2", err, 1);
    checkOutput("t3_no_restart", busy, 0);
    applyStimulus(2'd3, 6'h00);
    checkOutput("t3_err_tag3", err, 1);
    checkOutput("t3_err_cnt3", err_cnt, 3);
    sendFrame(1);
    @(posedge clk); #1;
    checkOutput("t3_frame_cnt", frame_cnt, 1);
    checkOutput("t3_err_cnt_keep", err_cnt, 3);

    // Timeout in S_F2, then an F2 landing on the final idle cycle.
    doReset();
    applyStimulus(TAG_F1, 6'h2D);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checkOutput("t4_before_timeout_busy", busy, 1);
    checkOutput("t4_before_timeout_err", err, 0);
    @(posedge clk); #1;
    checkOutput("t4_timeout_err", err, 1);
    checkOutput("t4_timeout_busy", busy, 0);
    checkOutput("t4_timeout_err_cnt", err_cnt, 1);
    sb.push_back({frames[0].ex1, frames[0].ex2});
    applyStimulus(TAG_F1, frames[0].f1);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    applyStimulus(TAG_F2, frames[0].f2);
    checkOutput("t4_late_f2_err", err, 0);
    checkOutput("t4_late_f2_busy", busy, 1);
    applyStimulus(TAG_F3, frames[0].f3);
    @(posedge clk); #1;
    checkOutput("t4_late_frame_cnt", frame_cnt, 1);
    checkOutput("t4_late_err_cnt", err_cnt, 1);

    // err_cnt saturation, then frame_cnt wrap.
    doReset();
    for (int i = 0; i < 255; i++) applyStimulus(2'd3, 6'h00);
    checkOutput("t5_err_cnt_full", err_cnt, 8'hFF);
    applyStimulus(2'd3, 6'h00);
    applyStimulus(TAG_F2, 6'h00);
    checkOutput("t5_err_still_pulses", err, 1);
    checkOutput("t5_err_cnt_sat", err_cnt, 8'hFF);
    for (int i = 0; i < 256; i++) begin
      sendFrame(i % 3);
      @(posedge clk); #1;
      if (i == 254) checkOutput("t5_frame_cnt_ff", frame_cnt, 8'hFF);
      if (i == 255) checkOutput("t5_frame_cnt_wrap", frame_cnt, 8'h00);
    end

    // Asynchronous reset while err is high, in S_F3 and in S_OUT.
    applyStimulus(2'd3, 6'h00);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_err", err, 0);
    checkOutput("t6_rst_err_cnt", err_cnt, 0);
    doReset();
    sendFrame(2);
    @(posedge clk); #1;
    applyStimulus(TAG_F1, 6'h11);
    applyStimulus(TAG_F2, 6'h22);
    checkOutput("t6_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_f3_busy", busy, 0);
    checkOutput("t6_f3_in_ready", in_ready, 1);
    checkOutput("t6_f3_frame_cnt", frame_cnt, 0);
    doReset();
    out_ready = 1'b0;
    sendFrame(1);
    checkOutput("t6_pre_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_out_valid", out_valid, 0);
    checkOutput("t6_out_in_ready", in_ready, 1);
    checkOutput("t6_out_x1x2", {x1, x2}, 0);
    doReset();
    out_ready = 1'b1;
    sendFrame(2);
    @(posedge clk); #1;
    checkOutput("t6_post_frame_cnt", frame_cnt, 1);
    checkOutput("t6_post_err_cnt", err_cnt, 0);

    checkOutput("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
